// File: rtl/shifter_pipe.sv
// shifter_pipe: two-stage pipelined ARM operand-2 barrel shifter with carry-out.
//
// Stage 1 decodes the addressing mode into one normalised shift: a type, an
// amount and the flags n==0 / n==W / n>W / rrx. Stage 2 performs that shift and
// registers the result. A valid/ready handshake sits on each side, and a
// transfer happens only when valid and ready are both high.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational, 0 in reset)
//   in_mode               00 imm-rotate, 01 imm-amount, 10 reg-amount, 11 pass
//   in_value              Rm
//   in_operand            12-bit operand-2 field
//   in_rs                 Rs[7:0] amount (mode 10)
//   in_carry              current C flag
//   in_tag                sideband, returned with the result
//   out_valid / out_ready output handshake
//   out_result, out_carry shifted operand and shifter carry-out
//   out_tag               tag of this result
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_value,
  input  logic [11:0]      in_operand,
  input  logic [7:0]       in_rs,
  input  logic             in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);
  localparam int AW = $clog2(WIDTH);
  localparam logic [8:0] W9 = 9'(WIDTH);

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  localparam logic [1:0] M_IMM_ROT = 2'b00;
  localparam logic [1:0] M_IMM_SH  = 2'b01;
  localparam logic [1:0] M_REG_SH  = 2'b10;

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = s2_load || !s1_valid;
  assign in_ready  = s1_load && !reset;
  assign out_valid = s2_valid;

  // ---------------- decode ----------------
  // Every mode is folded into (type, n, value). The immediate rotate becomes
  // a ROR of the zero-extended imm8 by 2*rot: rot==0 then lands on the n==0
  // pass-through (carry = c_in), and otherwise the ROR carry equals result[W-1].
  logic [1:0]       d_type;
  logic [8:0]       d_n;
  logic [WIDTH-1:0] d_val;
  logic             d_rrx;

  always_comb begin
    d_type = in_operand[6:5];
    d_n    = 9'd0;
    d_val  = in_value;
    d_rrx  = 1'b0;
    case (in_mode)
      M_IMM_ROT: begin
        d_type = T_ROR;
        d_n    = {4'd0, in_operand[11:8], 1'b0};
        d_val  = WIDTH'(in_operand[7:0]);
      end
      M_IMM_SH: begin
        d_n = {4'd0, in_operand[11:7]};
        if (in_operand[11:7] == 5'd0) begin
          case (in_operand[6:5])
            T_LSR, T_ASR: d_n = W9;     // #0 encodes a shift by 32/W
            T_ROR:        d_rrx = 1'b1;
            default:      ;             // LSL #0 passes through
          endcase
        end
      end
      M_REG_SH: d_n = {1'b0, in_rs};
      default:  d_n = 9'd0;             // pass-through
    endcase
  end

  // ---------------- stage 1 registers ----------------
  logic [1:0]       s1_type;
  logic [AW-1:0]    s1_amt;   // n mod W; only meaningful for n < W and for ROR
  logic [WIDTH-1:0] s1_val;
  logic             s1_c;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_zero, s1_eq_w, s1_gt_w, s1_rrx;

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_type <= d_type;
      s1_amt  <= d_n[AW-1:0];
      s1_val  <= d_val;
      s1_c    <= in_carry;
      s1_tag  <= in_tag;
      s1_zero <= (d_n == 9'd0);
      s1_eq_w <= (d_n == W9);
      s1_gt_w <= (d_n > W9);
      s1_rrx  <= d_rrx;
    end
  end

  // ---------------- shift ----------------
  // One spare bit beside the value catches the last bit shifted out, which
  // gives the carry for in-range LSL/LSR/ASR without a separate bit select.
  logic [WIDTH:0]        lsl_t, lsr_t;
  logic signed [WIDTH:0] asr_t;
  logic [WIDTH-1:0]      ror_t;
  logic [WIDTH-1:0]      sh_res;
  logic                  sh_c;

  always_comb begin
    lsl_t  = {1'b0, s1_val} << s1_amt;
    lsr_t  = {s1_val, 1'b0} >> s1_amt;
    asr_t  = $signed({s1_val, 1'b0}) >>> s1_amt;
    ror_t  = WIDTH'({s1_val, s1_val} >> s1_amt);
    sh_res = s1_val;
    sh_c   = s1_c;
    if (s1_rrx) begin
      sh_res = {s1_c, s1_val[WIDTH-1:1]};
      sh_c   = s1_val[0];
    end else if (!s1_zero) begin
      case (s1_type)
        T_LSL: begin
          if (s1_gt_w)      begin sh_res = '0; sh_c = 1'b0;      end
          else if (s1_eq_w) begin sh_res = '0; sh_c = s1_val[0]; end
          else              begin sh_res = lsl_t[WIDTH-1:0]; sh_c = lsl_t[WIDTH]; end
        end
        T_LSR: begin
          if (s1_gt_w)      begin sh_res = '0; sh_c = 1'b0;            end
          else if (s1_eq_w) begin sh_res = '0; sh_c = s1_val[WIDTH-1]; end
          else              begin sh_res = lsr_t[WIDTH:1]; sh_c = lsr_t[0]; end
        end
        T_ASR: begin
          if (s1_gt_w || s1_eq_w) begin
            sh_res = {WIDTH{s1_val[WIDTH-1]}};
            sh_c   = s1_val[WIDTH-1];
          end else begin
            sh_res = asr_t[WIDTH:1];
            sh_c   = asr_t[0];
          end
        end
        default: begin
          // A rotate by a multiple of W (n != 0) leaves v unchanged and takes
          // carry v[W-1]; that is the same result[W-1] rule as other amounts.
          sh_res = ror_t;
          sh_c   = ror_t[WIDTH-1];
        end
      endcase
    end
  end

  // ---------------- valids and stage 2 ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_tag    <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= sh_res;
          out_carry  <= sh_c;
          out_tag    <= s1_tag;
        end
      end
    end
  end
endmodule
